// File: rtl/jtdd2_share_arb.sv
// rtl/jtdd2_share_arb.sv - BUSRQ/BUSAK arbiter for the main/MCU shared RAM window
// Build option JTDD2_ARB_AUTOREQ_EN: shared-window accesses raise the bus request by themselves.
module jtdd2_share_arb #(
    parameter int TOUT_W  = 8,
    parameter int REL_DLY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic halt_set,
    input  logic halt_clr,
    input  logic com_cs,
    input  logic sub_busak_n,
    output logic sub_busrq_n,
    output logic grant,
    output logic main_wait,
    output logic timeout,
    output logic blocked
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] GNT     = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam int REL_W = (REL_DLY < 2) ? 1 : $clog2(REL_DLY + 1);
    // Last count value before the counter would reach all-ones
    localparam logic [TOUT_W-1:0] TOUT_LAST = {{(TOUT_W-1){1'b1}}, 1'b0};
    localparam logic [REL_W-1:0]  REL_LAST  = REL_W'((REL_DLY > 0) ? REL_DLY - 1 : 0);

    logic [1:0]        state;
    logic              halt_bit;
    logic [TOUT_W-1:0] tout_cnt;
    logic [REL_W-1:0]  rel_cnt;
    logic              req;
    logic              tout_fire;

    assign tout_fire = (state == REQ) && sub_busak_n && (tout_cnt == TOUT_LAST);

`ifdef JTDD2_ARB_AUTOREQ_EN
    assign req       = halt_bit | com_cs;
    assign main_wait = com_cs & ~grant & ((state == REQ) | ((state == IDLE) & req));
    assign blocked   = 1'b0;
`else
    logic blocked_r;

    assign req       = halt_bit;
    assign main_wait = 1'b0;
    assign blocked   = blocked_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            blocked_r <= 1'b0;
        end else if (cen) begin
            blocked_r <= com_cs & ~grant;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            halt_bit    <= 1'b0;
            tout_cnt    <= '0;
            rel_cnt     <= '0;
            sub_busrq_n <= 1'b1;
            grant       <= 1'b0;
            timeout     <= 1'b0;
        end else if (cen) begin
            if (halt_set) begin
                halt_bit <= 1'b1;
            end else if (halt_clr || tout_fire) begin
                halt_bit <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        state       <= REQ;
                        tout_cnt    <= '0;
                        sub_busrq_n <= 1'b0;
                    end
                end
                REQ: begin
                    // An acknowledge on the terminal tick still wins over the timeout
                    if (!sub_busak_n) begin
                        state   <= GNT;
                        grant   <= 1'b1;
                        timeout <= 1'b0;
                    end else if (tout_fire) begin
                        state       <= IDLE;
                        sub_busrq_n <= 1'b1;
                        timeout     <= 1'b1;
                    end else begin
                        tout_cnt <= tout_cnt + 1'b1;
                    end
                end
                GNT: begin
                    if (!req) begin
                        state       <= RELEASE;
                        grant       <= 1'b0;
                        sub_busrq_n <= 1'b1;
                        rel_cnt     <= '0;
                    end
                end
                default: begin
                    // Requests arriving here wait until IDLE is reached
                    if (sub_busak_n) begin
                        if (rel_cnt == REL_LAST) begin
                            state <= IDLE;
                        end else begin
                            rel_cnt <= rel_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtdd2_share_arb.sv
// tb/tb_jtdd2_share_arb.sv - randomized and directed check of jtdd2_share_arb against a tick model
module tb_jtdd2_share_arb;

    localparam int TW  = 4;
    localparam int REL = 2;
`ifdef JTDD2_ARB_AUTOREQ_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1, cen = 1'b0, halt_set = 1'b0, halt_clr = 1'b0, com_cs = 1'b0, sub_busak_n = 1'b1;
    logic sub_busrq_n, grant, main_wait, timeout, blocked;

    int n_checks = 0;
    int n_fail   = 0;

    jtdd2_share_arb #(.TOUT_W(TW), .REL_DLY(REL)) dut (
        .clk(clk), .rst(rst), .cen(cen), .halt_set(halt_set), .halt_clr(halt_clr),
        .com_cs(com_cs), .sub_busak_n(sub_busak_n), .sub_busrq_n(sub_busrq_n),
        .grant(grant), .main_wait(main_wait), .timeout(timeout), .blocked(blocked)
    );

    always #5 clk = ~clk;

    // Bus ownership phases as seen from the main CPU side
    typedef enum int { FREE, ASKING, OWNED, HANDBACK } owner_t;
    owner_t m_own = FREE;
    bit m_halt = 0, m_tout = 0, m_blk = 0;
    int m_asked = 0, m_quiet = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit c, input bit hs, input bit hc, input bit cs, input bit bk);
        bit want, gave_up;
        if (r) begin
            m_own = FREE; m_halt = 0; m_tout = 0; m_blk = 0; m_asked = 0; m_quiet = 0;
            return;
        end
        if (!c) return;
        want    = m_halt || (AUTO && cs);
        gave_up = 0;
        m_blk   = !AUTO && cs && (m_own != OWNED);
        if (m_own == FREE) begin
            if (want) begin m_own = ASKING; m_asked = 0; end
        end else if (m_own == ASKING) begin
            if (!bk) begin
                m_own = OWNED; m_tout = 0;
            end else if (m_asked + 1 == (1 << TW) - 1) begin
                m_own = FREE; m_tout = 1; gave_up = 1;
            end else begin
                m_asked++;
            end
        end else if (m_own == OWNED) begin
            if (!want) begin m_own = HANDBACK; m_quiet = 0; end
        end else begin
            if (bk) begin
                m_quiet++;
                if (m_quiet == REL) m_own = FREE;
            end
        end
        if (hs) m_halt = 1;
        else if (hc || gave_up) m_halt = 0;
    endtask

    task automatic tick(input bit r, input bit c, input bit hs, input bit hc, input bit cs, input bit bk);
        bit exp_wait;
        @(negedge clk);
        rst = r; cen = c; halt_set = hs; halt_clr = hc; com_cs = cs; sub_busak_n = bk;
        model_step(r, c, hs, hc, cs, bk);
        @(posedge clk);
        #1;
        exp_wait = AUTO && cs && (m_own != OWNED) &&
                   (m_own == ASKING || (m_own == FREE && (m_halt || cs)));
        check("busrq_n", sub_busrq_n, !(m_own == ASKING || m_own == OWNED));
        check("grant", grant, m_own == OWNED);
        check("timeout", timeout, m_tout);
        check("blocked", blocked, m_blk);
        check("main_wait", main_wait, exp_wait);
    endtask

    task automatic go_idle();
        tick(0, 1, 0, 1, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 1);
    endtask

    initial begin
        bit bk_r, dead, low;
        tick(1, 1, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 0, 1);
        check("rst_busrq_n", sub_busrq_n, 1);
        check("rst_grant", grant, 0);
        check("rst_timeout", timeout, 0);

        // Basic handshake, sub responds after 3 ticks
        tick(0, 1, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 1);
        check("hs_busrq_low", sub_busrq_n, 0);
        tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 1);
        check("hs_no_grant_yet", grant, 0);
        tick(0, 1, 0, 0, 0, 0);
        check("hs_grant", grant, 1);
        check("hs_timeout", timeout, 0);

        // Release, with a new halt request arriving mid-release
        tick(0, 1, 0, 1, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        check("rel_busrq_high", sub_busrq_n, 1);
        check("rel_grant_low", grant, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 1, 0, 0, 1);
        check("rel_held_1", sub_busrq_n, 1);
        tick(0, 1, 0, 0, 0, 1);
        check("rel_held_2", sub_busrq_n, 1);
        tick(0, 1, 0, 0, 0, 1);
        check("rel_req_after_idle", sub_busrq_n, 0);

        // Timeout: 15 ticks in REQ without acknowledge
        for (int i = 0; i < 14; i++) tick(0, 1, 0, 0, 0, 1);
        check("tout_not_yet", timeout, 0);
        tick(0, 1, 0, 0, 0, 1);
        check("tout_set", timeout, 1);
        check("tout_busrq_high", sub_busrq_n, 1);
        tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 1);
        check("tout_halt_cleared", sub_busrq_n, 1);
        check("tout_sticky", timeout, 1);

        // A later grant clears timeout
        tick(0, 1, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 0);
        check("regrant", grant, 1);
        check("regrant_tout_clr", timeout, 0);
        go_idle();

        // Set and clear together: set wins
        tick(0, 1, 1, 1, 0, 1);
        tick(0, 1, 0, 0, 0, 1);
        check("set_clr_set_wins", sub_busrq_n, 0);

        // Acknowledge on the terminal tick
        for (int i = 0; i < 14; i++) tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 0);
        check("term_grant", grant, 1);
        check("term_no_tout", timeout, 0);
        go_idle();

        // Spurious acknowledge while idle
        tick(0, 1, 0, 0, 0, 0);
        check("spurious_grant", grant, 0);
        tick(0, 1, 0, 0, 0, 1);

        // Shared-window access with no halt bit
        tick(0, 1, 0, 0, 1, 1);
`ifdef JTDD2_ARB_AUTOREQ_EN
        check("auto_wait", main_wait, 1);
        tick(0, 1, 0, 0, 1, 0);
        check("auto_grant", grant, 1);
        check("auto_wait_off", main_wait, 0);
        tick(0, 1, 0, 0, 0, 0);
        check("auto_release", sub_busrq_n, 1);
`else
        check("blk_pulse", blocked, 1);
        check("blk_wait", main_wait, 0);
        check("blk_busrq", sub_busrq_n, 1);
        tick(0, 1, 0, 0, 0, 1);
        check("blk_end", blocked, 0);
`endif
        tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 1);

        // Reset mid-REQ after a timeout, then mid-GRANT
        tick(0, 1, 1, 0, 0, 1);
        for (int i = 0; i < 16; i++) tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 0, 1);
        check("rst_req_busrq", sub_busrq_n, 1);
        check("rst_req_tout", timeout, 0);
        tick(0, 1, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0);
        check("rst_gnt_busrq", sub_busrq_n, 1);
        check("rst_gnt_grant", grant, 0);
        check("rst_gnt_wait", main_wait, 0);

        // Random traffic with a sub CPU that is sometimes unresponsive
        bk_r = 1; dead = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) dead = ($urandom_range(0, 3) == 0);
            low = (m_own == ASKING || m_own == OWNED);
            if (low && !dead && $urandom_range(0, 3) == 0) bk_r = 0;
            else if (!low && !bk_r && $urandom_range(0, 2) == 0) bk_r = 1;
            else if (!low && bk_r && $urandom_range(0, 49) == 0) bk_r = 0;
            tick($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0, bk_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
